// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: bubble instruction and IF/ID occupancy states.
package cpu_pkg;

  // sll $0,$0,0 -- also used by the ID/EX flush path
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    HELD  = 2'd2
  } ifid_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold, flush-to-bubble and occupancy FSM.
// Optional stall/flush performance counters are compiled in with IFID_PERF_CNT_EN.
//
// state | meaning
// EMPTY | bubble held in ID
// VALID | fresh instruction loaded on the last edge
// HELD  | valid instruction retained by a stall
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INSTR)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] if_pc_plus4,
  input  logic [WIDTH-1:0] if_instr,
  input  logic             IFIDWrite,
  input  logic             flush,
  output logic [WIDTH-1:0] id_pc_plus4,
  output logic [WIDTH-1:0] id_instr,
  output logic             id_valid,
  output logic [1:0]       state
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  ifid_state_t state_q;
  ifid_state_t state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // flush outranks stall, stall outranks load
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (!IFIDWrite) begin
      case (state_q)
        VALID:   state_d = HELD;
        HELD:    state_d = HELD;
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = VALID;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_instr    <= NOP;
      id_pc_plus4 <= '0;
    end else if (flush) begin
      id_instr    <= NOP;
      id_pc_plus4 <= '0;
    end else if (IFIDWrite) begin
      id_instr    <= if_instr;
      id_pc_plus4 <= if_pc_plus4;
    end
  end

  assign id_valid = (state_q == VALID) || (state_q == HELD);
  assign state    = state_q;

`ifdef IFID_PERF_CNT_EN
  logic stall_event;
  assign stall_event = !flush && !IFIDWrite;

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .en    (stall_event),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .en    (flush),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed, table-driven bench for if_id_reg plus a narrow sat_counter instance for saturation.
module tb_if_id_reg;
  import cpu_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        IFIDWrite;
  logic        flush;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [1:0]  state;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  logic       sc_reset;
  logic       sc_en;
  logic [3:0] sc_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  if_id_reg dut (
    .clock       (clock),
    .reset       (reset),
    .if_pc_plus4 (if_pc_plus4),
    .if_instr    (if_instr),
    .IFIDWrite   (IFIDWrite),
    .flush       (flush),
    .id_pc_plus4 (id_pc_plus4),
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .state       (state)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  sat_counter #(.WIDTH(4)) u_sc (
    .clock (clock),
    .reset (sc_reset),
    .en    (sc_en),
    .count (sc_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        flush;
    logic        wr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic e_valid, input logic [1:0] e_state);
    check({tag, ".id_pc_plus4"}, id_pc_plus4, e_pc);
    check({tag, ".id_instr"}, id_instr, e_instr);
    check({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_valid});
    check({tag, ".state"}, {30'd0, state}, {30'd0, e_state});
`ifdef IFID_PERF_CNT_EN
    check({tag, ".stall_cnt"}, stall_cnt, exp_stall);
    check({tag, ".flush_cnt"}, flush_cnt, exp_flush);
`endif
  endtask

  // drive one edge's inputs, clock it, sample just after the edge
  task automatic step(input logic f, input logic wr, input logic [31:0] pc, input logic [31:0] instr);
    flush       = f;
    IFIDWrite   = wr;
    if_pc_plus4 = pc;
    if_instr    = instr;
    @(posedge clock);
    if (f) exp_flush++;
    else if (!wr) exp_stall++;
    #1;
  endtask

  initial begin
    //          flush wr  pc      instr           e_pc    e_instr         e_valid e_state
    vecs[0]  = '{1'b0, 1'b1, 32'd4,  32'h2008_0005, 32'd4,  32'h2008_0005, 1'b1, VALID};
    vecs[1]  = '{1'b0, 1'b1, 32'd8,  32'h0109_5020, 32'd8,  32'h0109_5020, 1'b1, VALID};
    vecs[2]  = '{1'b0, 1'b0, 32'd12, 32'hAAAA_AAAA, 32'd8,  32'h0109_5020, 1'b1, HELD};
    vecs[3]  = '{1'b0, 1'b0, 32'd16, 32'hBBBB_BBBB, 32'd8,  32'h0109_5020, 1'b1, HELD};
    vecs[4]  = '{1'b0, 1'b0, 32'd20, 32'hCCCC_CCCC, 32'd8,  32'h0109_5020, 1'b1, HELD};
    vecs[5]  = '{1'b1, 1'b0, 32'd24, 32'hDDDD_DDDD, 32'd0,  32'h0000_0000, 1'b0, EMPTY};
    vecs[6]  = '{1'b0, 1'b0, 32'd28, 32'hEEEE_EEEE, 32'd0,  32'h0000_0000, 1'b0, EMPTY};
    vecs[7]  = '{1'b0, 1'b1, 32'd4,  32'h1111_0001, 32'd4,  32'h1111_0001, 1'b1, VALID};
    vecs[8]  = '{1'b0, 1'b1, 32'd8,  32'h1111_0002, 32'd8,  32'h1111_0002, 1'b1, VALID};
    vecs[9]  = '{1'b0, 1'b1, 32'd12, 32'h1111_0003, 32'd12, 32'h1111_0003, 1'b1, VALID};
    vecs[10] = '{1'b0, 1'b1, 32'd16, 32'h1111_0004, 32'd16, 32'h1111_0004, 1'b1, VALID};
    vecs[11] = '{1'b1, 1'b1, 32'd20, 32'h1111_0005, 32'd0,  32'h0000_0000, 1'b0, EMPTY};
    vecs[12] = '{1'b0, 1'b1, 32'h20, 32'h0000_1234, 32'h20, 32'h0000_1234, 1'b1, VALID};

    reset       = 1'b1;
    sc_reset    = 1'b1;
    sc_en       = 1'b0;
    flush       = 1'b0;
    IFIDWrite   = 1'b1;
    if_pc_plus4 = 32'd0;
    if_instr    = 32'h0000_0000;
    #12;
    check_outputs("reset", 32'd0, NOP_INSTR, 1'b0, EMPTY);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].flush, vecs[i].wr, vecs[i].pc, vecs[i].instr);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_state);
    end

    // async reset while stalled: clears before any edge
    step(1'b0, 1'b0, 32'h44, 32'h9999_9999);
    check_outputs("pre_rst_held", 32'h20, 32'h0000_1234, 1'b1, HELD);
    @(negedge clock);
    reset = 1'b1;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    check_outputs("async_rst", 32'd0, NOP_INSTR, 1'b0, EMPTY);
    #2;
    reset = 1'b0;
    step(1'b0, 1'b1, 32'd4, 32'h2008_0005);
    check_outputs("post_rst_load", 32'd4, 32'h2008_0005, 1'b1, VALID);

    // stall straight after reset-release load, then flush-while-stall
    step(1'b0, 1'b0, 32'd8, 32'h5555_5555);
    check_outputs("stall_after_rst", 32'd4, 32'h2008_0005, 1'b1, HELD);
    step(1'b1, 1'b0, 32'd8, 32'h5555_5555);
    check_outputs("flush_stall", 32'd0, NOP_INSTR, 1'b0, EMPTY);

    // saturation on a 4-bit counter instance
    @(negedge clock);
    sc_reset = 1'b0;
    sc_en    = 1'b1;
    repeat (14) @(posedge clock);
    #1;
    check("sat.count14", {28'd0, sc_count}, 32'd14);
    @(posedge clock);
    #1;
    check("sat.count15", {28'd0, sc_count}, 32'd15);
    repeat (3) @(posedge clock);
    #1;
    check("sat.hold", {28'd0, sc_count}, 32'd15);
    sc_reset = 1'b1;
    #1;
    check("sat.reset", {28'd0, sc_count}, 32'd0);
    sc_reset = 1'b0;
    sc_en    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("sat.disabled", {28'd0, sc_count}, 32'd0);
    sc_en = 1'b1;
    @(posedge clock);
    #1;
    check("sat.count1", {28'd0, sc_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
